// File: rtl/game_ctrl.sv
// game_ctrl: game state controller for a driving game.
// Registers per-channel obstacle overlap each cycle, then runs the
// IDLE/PLAY/CRASH/OVER flow that tracks lives, score and the crash animation.
module game_ctrl #(
  parameter int N_OBS        = 6,
  parameter int LIVES        = 3,
  parameter int CRASH_FRAMES = 60,
  parameter int SCORE_W      = 16,
  parameter int CAR_W        = 16,
  parameter int CAR_H        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 start,
  input  logic [7:0]           player_x,
  input  logic [9:0]           player_y,
  input  logic [N_OBS-1:0]     obs_on,
  input  logic [8*N_OBS-1:0]   obs_x,
  input  logic [10*N_OBS-1:0]  obs_y,
  output logic [1:0]           state,
  output logic [2:0]           lives,
  output logic [SCORE_W-1:0]   score,
  output logic                 freeze,
  output logic                 blink,
  output logic                 hit,
  output logic [3:0]           hit_idx,
  output logic                 game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_CRASH = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t               state_d, state_q;
  logic [2:0]           lives_d, lives_q;
  logic [SCORE_W-1:0]   score_d, score_q;
  logic [7:0]           cnt_d, cnt_q;
  logic                 hit_d, hit_q;
  logic [3:0]           hit_idx_d, hit_idx_q;
  logic                 blink_d, blink_q;
  logic                 freeze_d, freeze_q;
  logic                 game_over_d, game_over_q;
  logic [N_OBS-1:0]     hit_vec_d, hit_vec_q;
  logic [3:0]           low_idx;

  // Per-channel box overlap. Coordinates are zero-extended to 11 bits so the
  // absolute difference never wraps (x=0 and x=255 are far apart).
  for (genvar gi = 0; gi < N_OBS; gi++) begin : g_ovl
    logic [10:0] ox, px, oy, py, dx, dy;
    assign ox = {3'b000, obs_x[8*gi +: 8]};
    assign px = {3'b000, player_x};
    assign oy = {1'b0, obs_y[10*gi +: 10]};
    assign py = {1'b0, player_y};
    assign dx = (ox >= px) ? (ox - px) : (px - ox);
    assign dy = (oy >= py) ? (oy - py) : (py - oy);
    assign hit_vec_d[gi] = obs_on[gi] & (dx < 11'(CAR_W)) & (dy < 11'(CAR_H));
  end

  // Priority pick: lowest colliding channel wins.
  always_comb begin
    low_idx = 4'd0;
    for (int i = N_OBS - 1; i >= 0; i--) begin
      if (hit_vec_q[i]) low_idx = 4'(i);
    end
  end

  // Next-state and next-output logic; every output is computed from the
  // next state so the registered outputs line up with the registered state.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    hit_idx_d = hit_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PLAY;
          lives_d = 3'(LIVES);
          score_d = '0;
        end
      end
      S_PLAY: begin
        // A collision takes priority over a coincident frame tick.
        if (|hit_vec_q) begin
          state_d   = S_CRASH;
          lives_d   = lives_q - 3'd1;
          cnt_d     = 8'd0;
          hit_d     = 1'b1;
          hit_idx_d = low_idx;
        end else if (frame_tick && (score_q != {SCORE_W{1'b1}})) begin
          score_d = score_q + SCORE_W'(1);
        end
      end
      S_CRASH: begin
        if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(CRASH_FRAMES)) begin
            state_d = (lives_q != 3'd0) ? S_PLAY : S_OVER;
          end
        end
      end
      S_OVER: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    freeze_d    = (state_d != S_PLAY);
    game_over_d = (state_d == S_OVER);
    // Counter bit 2 gives four ticks off, four ticks on, starting off.
    blink_d     = (state_d == S_CRASH) ? cnt_d[2] : 1'b1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lives_q     <= 3'(LIVES);
      score_q     <= '0;
      cnt_q       <= 8'd0;
      hit_q       <= 1'b0;
      hit_idx_q   <= 4'd0;
      blink_q     <= 1'b1;
      freeze_q    <= 1'b1;
      game_over_q <= 1'b0;
      hit_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      blink_q     <= blink_d;
      freeze_q    <= freeze_d;
      game_over_q <= game_over_d;
      hit_vec_q   <= hit_vec_d;
    end
  end

  assign state     = state_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;
  assign blink     = blink_q;
  assign freeze    = freeze_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: vector table, directed crash/game-over sequences and a
// randomized run checked against a behavioural model of the game rules.
module tb_game_ctrl;
  localparam int N_OBS        = 6;
  localparam int LIVES        = 3;
  localparam int CRASH_FRAMES = 60;
  localparam int SCORE_W      = 6;   // small so saturation is reachable quickly
  localparam int CAR_W        = 16;
  localparam int CAR_H        = 32;
  localparam int SMAX         = (1 << SCORE_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset, frame_tick, start;
  logic [7:0]           player_x;
  logic [9:0]           player_y;
  logic [N_OBS-1:0]     obs_on;
  logic [8*N_OBS-1:0]   obs_x;
  logic [10*N_OBS-1:0]  obs_y;
  logic [1:0]           state;
  logic [2:0]           lives;
  logic [SCORE_W-1:0]   score;
  logic                 freeze, blink, hit, game_over;
  logic [3:0]           hit_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_ctrl #(
    .N_OBS(N_OBS), .LIVES(LIVES), .CRASH_FRAMES(CRASH_FRAMES),
    .SCORE_W(SCORE_W), .CAR_W(CAR_W), .CAR_H(CAR_H)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .player_x(player_x), .player_y(player_y),
    .obs_on(obs_on), .obs_x(obs_x), .obs_y(obs_y),
    .state(state), .lives(lives), .score(score), .freeze(freeze),
    .blink(blink), .hit(hit), .hit_idx(hit_idx), .game_over(game_over)
  );

  // ---------------- behavioural reference model ----------------
  // Game rules expressed directly: mode 0..3, counts as plain integers.
  int m_mode, m_lives, m_score, m_ticks, m_hit, m_idx;
  int m_pending[$];   // channels overlapping at the previous clock edge

  function automatic void model_step();
    int now[$];
    for (int i = 0; i < N_OBS; i++) begin
      int ax, ay;
      ax = int'(obs_x[8*i +: 8]) - int'(player_x);
      ay = int'(obs_y[10*i +: 10]) - int'(player_y);
      if (ax < 0) ax = -ax;
      if (ay < 0) ay = -ay;
      if (obs_on[i] && ax < CAR_W && ay < CAR_H) now.push_back(i);
    end
    if (reset) begin
      m_mode = 0; m_lives = LIVES; m_score = 0; m_ticks = 0; m_hit = 0; m_idx = 0;
      m_pending.delete();
      return;
    end
    m_hit = 0;
    if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_lives = LIVES; m_score = 0; end
    end else if (m_mode == 1) begin
      if (m_pending.size() > 0) begin
        m_mode = 2; m_lives = m_lives - 1; m_ticks = 0; m_hit = 1;
        m_idx = m_pending[0];     // collected in ascending channel order
      end else if (frame_tick) begin
        m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
      end
    end else if (m_mode == 2) begin
      if (frame_tick) begin
        m_ticks++;
        if (m_ticks == CRASH_FRAMES) m_mode = (m_lives > 0) ? 1 : 3;
      end
    end else begin
      if (start) m_mode = 0;
    end
    m_pending = now;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Negative expectation means "not checked here".
  task automatic chk_out(input string tag, input int st, input int lv, input int sc,
                         input int ht, input int idx, input int bl);
    if (st >= 0) begin
      chk({tag, ".state"}, int'(state), st);
      chk({tag, ".freeze"}, int'(freeze), (st != 1) ? 1 : 0);
      chk({tag, ".game_over"}, int'(game_over), (st == 3) ? 1 : 0);
    end
    if (lv >= 0)  chk({tag, ".lives"}, int'(lives), lv);
    if (sc >= 0)  chk({tag, ".score"}, int'(score), sc);
    if (ht >= 0)  chk({tag, ".hit"}, int'(hit), ht);
    if (idx >= 0) chk({tag, ".hit_idx"}, int'(hit_idx), idx);
    if (bl >= 0)  chk({tag, ".blink"}, int'(blink), bl);
  endtask

  task automatic set_in(input int px, input int py, input logic [N_OBS-1:0] on,
                        input int ox, input int oy);
    player_x = 8'(px);
    player_y = 10'(py);
    obs_on   = on;
    for (int i = 0; i < N_OBS; i++) begin
      obs_x[8*i +: 8]   = 8'(ox);
      obs_y[10*i +: 10] = 10'(oy);
    end
  endtask

  // One clock: drive controls, let the edge happen, advance the model, settle.
  task automatic cyc(input logic r, input logic s, input logic t);
    reset = r; start = s; frame_tick = t;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string tag;
    logic r, s, t;
    logic [N_OBS-1:0] on;
    int px, py, ox, oy;
    int e_st, e_lv, e_sc, e_hit, e_idx, e_bl;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input string tag, input logic r, input logic s, input logic t,
                              input logic [N_OBS-1:0] on, input int px, input int py,
                              input int ox, input int oy, input int e_st, input int e_lv,
                              input int e_sc, input int e_hit, input int e_idx, input int e_bl);
    vec_t v;
    v.tag = tag; v.r = r; v.s = s; v.t = t; v.on = on;
    v.px = px; v.py = py; v.ox = ox; v.oy = oy;
    v.e_st = e_st; v.e_lv = e_lv; v.e_sc = e_sc; v.e_hit = e_hit; v.e_idx = e_idx; v.e_bl = e_bl;
    tbl.push_back(v);
  endfunction

  initial begin
    // reset, start, ten frames (start re-asserted during PLAY is ignored)
    add("reset",     1, 0, 0, 6'b000000, 100, 200,   0,   0, 0, 3, 0, 0, 0, 1);
    add("idle",      0, 0, 0, 6'b000000, 100, 200,   0,   0, 0, 3, 0, 0, 0, 1);
    add("idle_tick", 0, 0, 1, 6'b000000, 100, 200,   0,   0, 0, 3, 0, 0, 0, 1);
    add("start",     0, 1, 0, 6'b000000, 100, 200,   0,   0, 1, 3, 0, 0, 0, 1);
    for (int k = 1; k <= 10; k++)
      add("play_tick", 0, (k == 3), 1, 6'b000000, 100, 200, 0, 0, 1, 3, k, 0, 0, 1);
    // near misses and disabled channels: no collision
    for (int k = 0; k < 2; k++) begin
      add("off_overlap", 0, 0, 0, 6'b000000, 100, 200, 100, 200, 1, 3, 10, 0, 0, 1);
      add("x_plus16",    0, 0, 0, 6'b000100, 100, 200, 116, 200, 1, 3, 10, 0, 0, 1);
      add("x_minus16",   0, 0, 0, 6'b000100, 100, 200,  84, 200, 1, 3, 10, 0, 0, 1);
      add("y_plus32",    0, 0, 0, 6'b000100, 100, 200, 100, 232, 1, 3, 10, 0, 0, 1);
      add("wrap_0_255",  0, 0, 0, 6'b000100,   0, 200, 255, 200, 1, 3, 10, 0, 0, 1);
      add("wrap_255_0",  0, 0, 0, 6'b000100, 255, 200,   0, 200, 1, 3, 10, 0, 0, 1);
    end
    // x+15 overlaps: hit appears on the second edge after the change
    add("x_plus15_a", 0, 0, 0, 6'b000100, 100, 200, 115, 200, 1, 3, 10, 0, 0, 1);
    add("x_plus15_b", 0, 0, 0, 6'b000100, 100, 200, 115, 200, 2, 2, 10, 1, 2, 0);
    add("crash_hold", 0, 0, 0, 6'b000100, 100, 200, 115, 200, 2, 2, 10, 0, 2, 0);

    foreach (tbl[i]) begin
      set_in(tbl[i].px, tbl[i].py, tbl[i].on, tbl[i].ox, tbl[i].oy);
      cyc(tbl[i].r, tbl[i].s, tbl[i].t);
      $display("vec %0d %s: state=%0d lives=%0d score=%0d hit=%0d idx=%0d",
               i, tbl[i].tag, state, lives, score, hit, hit_idx);
      chk_out(tbl[i].tag, tbl[i].e_st, tbl[i].e_lv, tbl[i].e_sc,
              tbl[i].e_hit, tbl[i].e_idx, tbl[i].e_bl);
    end

    // ---- crash 1: overlap stays on, 60 ticks, blink pattern, start ignored ----
    for (int k = 1; k <= CRASH_FRAMES; k++) begin
      cyc(0, (k == 30), 1);
      if (k < CRASH_FRAMES) chk_out("crash1", 2, 2, 10, 0, 2, (k / 4) % 2);
      else                  chk_out("crash1_exit", 1, 2, 10, 0, 2, 1);
    end
    $display("seq crash1 done: state=%0d lives=%0d", state, lives);
    // overlap still registered, tick in the same cycle: collision wins
    cyc(0, 0, 1);
    chk_out("hit_and_tick", 2, 1, 10, 1, 2, 0);
    $display("seq hit_and_tick: score=%0d lives=%0d", score, lives);

    // ---- crash 2 with the obstacle removed ----
    set_in(100, 200, 6'b000000, 100, 200);
    for (int k = 1; k <= CRASH_FRAMES; k++) begin
      cyc(0, 0, 1);
      if (k == CRASH_FRAMES - 1) chk_out("crash2_last", 2, 1, 10, 0, 2, 0);
      if (k == CRASH_FRAMES)     chk_out("crash2_exit", 1, 1, 10, 0, 2, 1);
    end
    $display("seq crash2 done: state=%0d lives=%0d", state, lives);

    // ---- channels 1 and 4 together, last life, then game over ----
    set_in(100, 200, 6'b010010, 103, 195);
    cyc(0, 0, 0);
    chk_out("dual_a", 1, 1, 10, 0, 2, 1);
    cyc(0, 0, 0);
    chk_out("dual_b", 2, 0, 10, 1, 1, 0);
    for (int k = 1; k <= CRASH_FRAMES; k++) begin
      cyc(0, 0, 1);
      if (k < CRASH_FRAMES) chk_out("crash3", 2, 0, 10, 0, 1, -1);
      else                  chk_out("crash3_over", 3, 0, 10, 0, 1, 1);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1);
      chk_out("over_hold", 3, 0, 10, 0, 1, 1);
    end
    $display("seq game_over: state=%0d game_over=%0d score=%0d", state, game_over, score);
    set_in(100, 200, 6'b000000, 100, 200);
    cyc(0, 1, 0);
    chk_out("over_to_idle", 0, -1, -1, 0, 1, 1);
    cyc(0, 1, 0);
    chk_out("restart", 1, 3, 0, 0, 1, 1);
    $display("seq restart: state=%0d lives=%0d score=%0d", state, lives, score);

    // ---- score saturation ----
    for (int k = 1; k <= SMAX + 7; k++) begin
      cyc(0, 0, 1);
      chk_out("saturate", 1, 3, (k > SMAX) ? SMAX : k, 0, -1, 1);
    end
    $display("seq saturate: score=%0d", score);

    // ---- reset in the middle of a crash ----
    set_in(100, 200, 6'b001000, 100, 200);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk_out("crash4", 2, 2, SMAX, 1, 3, 0);
    for (int k = 1; k <= 5; k++) cyc(0, 0, 1);
    chk_out("crash4_mid", 2, 2, SMAX, 0, 3, 1);
    cyc(1, 1, 1);
    chk_out("reset_mid_crash", 0, 3, 0, 0, 0, 1);
    cyc(0, 0, 0);
    chk_out("after_reset", 0, 3, 0, 0, 0, 1);
    $display("seq reset_mid_crash: state=%0d lives=%0d idx=%0d", state, lives, hit_idx);

    // ---- randomized run against the model ----
    cyc(1, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      int px, py;
      px = int'($urandom_range(0, 255));
      py = int'($urandom_range(0, 1023));
      player_x = 8'(px);
      player_y = 10'(py);
      for (int i = 0; i < N_OBS; i++) begin
        obs_on[i] = ($urandom_range(0, 9) == 0);
        obs_x[8*i +: 8]   = 8'((px + int'($urandom_range(0, 40)) - 20) & 255);
        obs_y[10*i +: 10] = 10'((py + int'($urandom_range(0, 80)) - 40) & 1023);
      end
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
      chk("rnd.state", int'(state), m_mode);
      chk("rnd.lives", int'(lives), m_lives);
      chk("rnd.score", int'(score), m_score);
      chk("rnd.hit", int'(hit), m_hit);
      chk("rnd.hit_idx", int'(hit_idx), m_idx);
      chk("rnd.blink", int'(blink), (m_mode == 2) ? (m_ticks / 4) % 2 : 1);
      chk("rnd.freeze", int'(freeze), (m_mode != 1) ? 1 : 0);
      chk("rnd.game_over", int'(game_over), (m_mode == 3) ? 1 : 0);
      if (m_hit != 0)
        $display("rnd %0d hit: idx=%0d lives=%0d score=%0d", n, m_idx, m_lives, m_score);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
